// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter FSM state type for the ALU sharing logic.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // ptr < NUM_REQ, so a single conditional subtract performs the wrap
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      idx = sum[IDX_W-1:0];
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU among NUM_REQ requesters;
// one operation per IDLE -> ISSUE -> CAPTURE pass, result returned with a 1-cycle pulse.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]    req_op,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [DATA_W-1:0]       resp_result,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [1:0]              alu_opcode,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ-1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [1:0]         sel_op;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (arb_any) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    req_ready = (state == ST_IDLE) ? arb_grant : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
    end else begin
      resp_valid <= '0;
      if (state == ST_IDLE && arb_any) begin
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        alu_opcode <= sel_op;
        grant_idx  <= arb_idx;
        rr_ptr     <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
      end
      // ALU registered its result at the end of ISSUE; alu_result is only trusted here
      if (state == ST_CAPTURE) begin
        resp_result <= alu_result;
        resp_valid  <= NUM_REQ'(1) << grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a registered ALU model and a behavioural arbiter model.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*2-1:0] req_op;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic [1:0]     alu_opcode;
  logic           busy;

  logic       rv[N];
  logic [7:0] ra[N];
  logic [7:0] rb[N];
  logic [1:0] rop[N];

  typedef struct {
    int unsigned idx;
    logic [7:0]  res;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned mptr = 0;
  int unsigned k = 3;
  logic        hs[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x & y;
      default: return x | y;
    endcase
  endfunction

  // Registered ALU with no reset, as seen by the arbiter
  always @(posedge clk) alu_result <= ref_alu(alu_opcode, alu_a, alu_b);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rv[i];
      req_a[i*W +: W]    = ra[i];
      req_b[i*W +: W]    = rb[i];
      req_op[i*2 +: 2]   = rop[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response is presented
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp at cycle %0d: got %b expected none", cyc, resp_valid);
      end else begin
        e = sb.pop_front();
        if (resp_valid !== (4'b1 << e.idx) || resp_result !== e.res || cyc != e.due) begin
          errors++;
          $display("FAIL resp at cycle %0d: got valid=%b result=%h expected valid=%b result=%h due=%0d",
                   cyc, resp_valid, resp_result, 4'b1 << e.idx, e.res, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp at cycle %0d: got none expected req%0d result %h", cyc, e.idx, e.res);
    end
  end

  // Model: arbiter is free three cycles after a grant; grants go round-robin from the last winner
  task automatic model_step();
    int g;
    g = -1;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (int'(mptr) + off) % N;
      if (g < 0 && rv[idx]) g = idx;
    end
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    chk("busy", 32'(busy), 32'(k < 3));
    if (k >= 3 && g >= 0) begin
      chk("grant", 32'(req_ready), 32'(4'b1 << g));
      hs[g] = 1'b1;
      sb.push_back('{idx: g, res: ref_alu(rop[g], ra[g], rb[g]), due: cyc + 3});
      mptr = (g + 1) % N;
      k = 0;
    end else begin
      chk("no_ready", 32'(req_ready), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (k < 3) k++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        rv[i] = 1'b0;
        hs[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    rv[i] = 1'b1; rop[i] = op; ra[i] = x; rb[i] = y;
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      if (!(rv[0] | rv[1] | rv[2] | rv[3]) && sb.size() == 0) return;
      tick();
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; hs[i] = 1'b0;
    end
    sb.delete();
    mptr = 0;
    k = 3;
    repeat (2) begin
      @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_result", 32'(resp_result), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_op", 32'(alu_opcode), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0; hs[i] = 1'b0;
    end
    apply_reset();

    set_req(0, 2'b00, 8'h12, 8'h34);
    drain();

    apply_reset();
    set_req(0, 2'b01, 8'h50, 8'h10);
    set_req(1, 2'b10, 8'hF0, 8'h3C);
    set_req(2, 2'b11, 8'hF0, 8'h0F);
    set_req(3, 2'b00, 8'h01, 8'h02);
    drain();

    set_req(1, 2'b00, 8'hFF, 8'h01);
    set_req(2, 2'b01, 8'h00, 8'h01);
    drain();

    for (int t = 0; t < 40; t++) begin
      if (!rv[0]) set_req(0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      if (!rv[2]) set_req(2, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      tick();
    end
    drain();

    // Reset while the granted op sits in ISSUE: it must vanish without a response
    set_req(1, 2'b01, 8'h77, 8'h11);
    for (int n = 0; n < 10 && rv[1]; n++) tick();
    apply_reset();
    set_req(3, 2'b00, 8'h05, 8'h05);
    drain();

    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0)
          set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      tick();
    end
    drain();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
